// File: rtl/error_dac_drive.sv
// Integrates +/-DAPL steps into a saturating signed error count and drives
// a sign-magnitude PWM whose duty is latched only at the start of each period.
module error_dac_drive #(
  parameter int LIMIT    = 384,
  parameter int PWM_BITS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pdapl,
  input  logic       mdapl,
  input  logic       err_en,
  input  logic       ovf_clr,
  output logic [9:0] count,
  output logic       sign,
  output logic       pwm,
  output logic       zero,
  output logic       ovf,
  output logic       period_start
);
  localparam int CW = 10;
  localparam logic signed [CW-1:0] LIM_P = CW'(LIMIT);
  localparam logic signed [CW-1:0] LIM_N = CW'(-LIMIT);
  localparam logic signed [CW-1:0] ONE   = CW'(1);

  logic                       pd_q, pd_qq, md_q, md_qq;
  logic                       live_q;
  logic signed [CW-1:0]       count_q, count_d;
  logic                       zero_q, ovf_q, ovf_d;
  logic        [PWM_BITS-1:0] cnt_q, cnt_d;
  logic        [PWM_BITS-1:0] duty_q, duty_d;
  logic                       sign_q, sign_d, pwm_q;
  logic                       p_step, m_step, ps;
  logic        [CW-1:0]       mag;

  assign p_step = pd_q & ~pd_qq;
  assign m_step = md_q & ~md_qq;
  // live_q is low only on the first cycle after reset; the counter holds at 0
  // for that cycle so the first period_start lands one clock after rst drops.
  assign ps     = live_q && (cnt_q == '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (!err_en) begin
      count_d = '0;
    end else if (p_step && m_step) begin
      count_d = count_q;
    end else if (p_step) begin
      if (count_q == LIM_P) ovf_d = 1'b1;
      else                  count_d = count_q + ONE;
    end else if (m_step) begin
      if (count_q == LIM_N) ovf_d = 1'b1;
      else                  count_d = count_q - ONE;
    end
  end

  always_comb begin
    mag    = count_q[CW-1] ? CW'(-count_q) : CW'(count_q);
    duty_d = duty_q;
    sign_d = sign_q;
    if (ps) begin
      duty_d = err_en ? PWM_BITS'(mag) : '0;
      sign_d = err_en & count_q[CW-1];
    end
    cnt_d = live_q ? cnt_q + PWM_BITS'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pd_q    <= 1'b0;
      pd_qq   <= 1'b0;
      md_q    <= 1'b0;
      md_qq   <= 1'b0;
      live_q  <= 1'b0;
      count_q <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      duty_q  <= '0;
      sign_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      pd_q    <= pdapl;
      md_q    <= mdapl;
      // Prime qq from the raw input on the first cycle so a level already
      // high when reset releases is not mistaken for a rising edge.
      pd_qq   <= live_q ? pd_q : pdapl;
      md_qq   <= live_q ? md_q : mdapl;
      live_q  <= 1'b1;
      count_q <= count_d;
      zero_q  <= (count_d == '0);
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      sign_q  <= sign_d;
      pwm_q   <= (cnt_q < duty_d);
    end
  end

  assign count        = count_q;
  assign zero         = zero_q;
  assign ovf          = ovf_q;
  assign sign         = sign_q;
  assign pwm          = pwm_q;
  assign period_start = ps;
endmodule

// File: tb/tb_error_dac_drive.sv
// Directed bench for error_dac_drive: counting, saturation, overflow, PWM duty
// latching, enable and mid-period reset, with hand-computed expectations.
module tb_error_dac_drive;
  logic       clk = 1'b0;
  logic       rst, pdapl, mdapl, err_en, ovf_clr;
  logic [9:0] count;
  logic       sign, pwm, zero, ovf, period_start;
  int         checks = 0;
  int         errors = 0;

  error_dac_drive #(.LIMIT(384), .PWM_BITS(9)) dut (
    .clk(clk), .rst(rst), .pdapl(pdapl), .mdapl(mdapl), .err_en(err_en),
    .ovf_clr(ovf_clr), .count(count), .sign(sign), .pwm(pwm), .zero(zero),
    .ovf(ovf), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_p(input int n);
    repeat (n) begin pdapl = 1'b1; tick(1); pdapl = 1'b0; tick(2); end
  endtask

  task automatic pulse_m(input int n);
    repeat (n) begin mdapl = 1'b1; tick(1); mdapl = 1'b0; tick(2); end
  endtask

  task automatic zero_count();
    err_en = 1'b0; tick(1); err_en = 1'b1;
  endtask

  task automatic wait_ps();
    for (int k = 0; k < 600 && period_start !== 1'b1; k++) tick(1);
    checks++;
    if (period_start !== 1'b1) begin
      errors++; $display("FAIL wait_ps: period_start=%b required 1 within 600 clocks", period_start);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1; pdapl = 1'b0; mdapl = 1'b0; err_en = 1'b1; ovf_clr = 1'b0;
    tick(3);
    checks++;
    if ({count, zero, ovf, pwm, sign, period_start} !== {10'd0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL reset_vals: count=%h zero=%b ovf=%b pwm=%b sign=%b ps=%b required 0 1 0 0 0 0",
                         count, zero, ovf, pwm, sign, period_start);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (period_start !== 1'b1) begin
      errors++; $display("FAIL first_ps: period_start=%b required 1", period_start);
    end
    for (int i = 1; i <= 1024; i++) begin
      tick(1);
      if (period_start !== (i % 512 == 0)) bad++;
      if (count !== 10'd0 || zero !== 1'b1 || ovf !== 1'b0 || pwm !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_1024: %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_count();
    for (int k = 0; k < 5; k++) begin
      pdapl = 1'b1;
      tick(1);
      checks++;
      if (count !== 10'(k)) begin
        errors++; $display("FAIL step_early_%0d: count=%0d required %0d", k, count, k);
      end
      tick(1);
      checks++;
      if (count !== 10'(k + 1)) begin
        errors++; $display("FAIL step_edge2_%0d: count=%0d required %0d", k, count, k + 1);
      end
      tick(1); pdapl = 1'b0; tick(3);
    end
    pdapl = 1'b1; tick(50); pdapl = 1'b0; tick(2);
    checks++;
    if (count !== 10'd6) begin
      errors++; $display("FAIL held_level: count=%0d required 6", count);
    end
  endtask

  task automatic test_pos_sat();
    pulse_p(378);
    checks++;
    if (count !== 10'd384 || ovf !== 1'b0) begin
      errors++; $display("FAIL reach_limit: count=%0d ovf=%b required 384 0", count, ovf);
    end
    pulse_p(1);
    checks++;
    if (count !== 10'd384 || ovf !== 1'b1) begin
      errors++; $display("FAIL first_refuse: count=%0d ovf=%b required 384 1", count, ovf);
    end
    pulse_p(11);
    pulse_m(1);
    checks++;
    if (count !== 10'd383) begin
      errors++; $display("FAIL down_from_limit: count=%0d required 383", count);
    end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b required 0", ovf);
    end
    pulse_p(1);
    pdapl = 1'b1; tick(1);
    pdapl = 1'b0; ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b1 || count !== 10'd384) begin
      errors++; $display("FAIL set_beats_clr: ovf=%b count=%0d required 1 384", ovf, count);
    end
    tick(1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear2: ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_simul_neg();
    pdapl = 1'b1; mdapl = 1'b1; tick(1); pdapl = 1'b0; mdapl = 1'b0; tick(2);
    checks++;
    if (count !== 10'd384 || ovf !== 1'b0) begin
      errors++; $display("FAIL simul_cancel: count=%0d ovf=%b required 384 0", count, ovf);
    end
    zero_count();
    checks++;
    if (count !== 10'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL en_zero: count=%h zero=%b required 000 1", count, zero);
    end
    pulse_m(400);
    checks++;
    if (count !== 10'h280 || ovf !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL neg_limit: count=%h ovf=%b zero=%b required 280 1 0", count, ovf, zero);
    end
    wait_ps(); tick(1);
    checks++;
    if (sign !== 1'b1) begin
      errors++; $display("FAIL neg_sign: sign=%b required 1", sign);
    end
  endtask

  task automatic test_pwm();
    int bad1 = 0;
    int bad2 = 0;
    zero_count(); pulse_p(100);
    wait_ps(); tick(1);
    for (int i = 0; i < 512; i++) begin
      if (pwm !== (i < 100)) bad1++;
      pdapl = (i >= 150 && i < 350 && i % 2 == 0);
      tick(1);
    end
    pdapl = 1'b0;
    checks++;
    if (count !== 10'd200) begin
      errors++; $display("FAIL mid_update: count=%0d required 200", count);
    end
    for (int i = 0; i < 512; i++) begin
      if (pwm !== (i < 200)) bad2++;
      tick(1);
    end
    checks++;
    if (bad1 != 0) begin
      errors++; $display("FAIL pwm_duty100: %0d bad cycles required 0", bad1);
    end
    checks++;
    if (bad2 != 0) begin
      errors++; $display("FAIL pwm_duty200: %0d bad cycles required 0", bad2);
    end
    checks++;
    if (sign !== 1'b0) begin
      errors++; $display("FAIL pos_sign: sign=%b required 0", sign);
    end
  endtask

  task automatic test_enable();
    int bad1 = 0;
    int bad2 = 0;
    logic [9:0] c11 = 10'h3ff;
    zero_count(); pulse_p(37);
    wait_ps(); tick(1);
    for (int i = 0; i < 512; i++) begin
      if (pwm !== (i < 37)) bad1++;
      if (i == 11) c11 = count;
      if (i >= 11 && count !== 10'd0) bad1++;
      if (i == 10) err_en = 1'b0;
      pdapl = (i >= 20 && i < 60 && i % 2 == 0);
      tick(1);
    end
    pdapl = 1'b0;
    for (int i = 0; i < 512; i++) begin
      if (pwm !== 1'b0 || count !== 10'd0) bad2++;
      tick(1);
    end
    err_en = 1'b1; tick(3);
    checks++;
    if (c11 !== 10'd0) begin
      errors++; $display("FAIL en_off_next_edge: count=%0d required 0", c11);
    end
    checks++;
    if (bad1 != 0) begin
      errors++; $display("FAIL en_period_completes: %0d bad cycles required 0", bad1);
    end
    checks++;
    if (bad2 != 0) begin
      errors++; $display("FAIL en_next_duty0: %0d bad cycles required 0", bad2);
    end
    checks++;
    if (count !== 10'd0) begin
      errors++; $display("FAIL en_pulses_ignored: count=%0d required 0", count);
    end
  endtask

  task automatic test_reset_mid();
    pulse_m(20);
    wait_ps(); tick(6);
    checks++;
    if (count !== 10'h3EC || sign !== 1'b1 || pwm !== 1'b1 || ovf !== 1'b1) begin
      errors++; $display("FAIL pre_reset: count=%h sign=%b pwm=%b ovf=%b required 3ec 1 1 1",
                         count, sign, pwm, ovf);
    end
    rst = 1'b1; pdapl = 1'b1; tick(1);
    checks++;
    if ({count, zero, ovf, pwm, sign, period_start} !== {10'd0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL mid_reset: count=%h zero=%b ovf=%b pwm=%b sign=%b ps=%b required 0 1 0 0 0 0",
                         count, zero, ovf, pwm, sign, period_start);
    end
    rst = 1'b0; tick(1);
    checks++;
    if (period_start !== 1'b1) begin
      errors++; $display("FAIL ps_after_reset: period_start=%b required 1", period_start);
    end
    tick(4);
    checks++;
    if (count !== 10'd0) begin
      errors++; $display("FAIL high_at_release: count=%0d required 0", count);
    end
    pdapl = 1'b0; tick(2);
  endtask

  initial begin
    test_reset();
    test_count();
    test_pos_sat();
    test_simul_neg();
    test_pwm();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
